// File: rtl/wb_copy_dma.sv
// rtl/wb_copy_dma.sv - Wishbone pipelined single-beat memory-to-memory word copy master
//
// Copies len_i 32-bit words from src_i to dst_i, one read then one write per word,
// at ascending addresses. Each beat is a single pipelined request: stb is held only
// until the slave accepts it (stall low) and is never held into the ack cycle.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             launch a copy (sampled only while idle)
//   src_i, dst_i        byte addresses, bits [1:0] ignored
//   len_i               number of words to copy
//   busy_o              copy in progress (through the done cycle)
//   done_o, err_o       one-cycle completion pulse; err_o marks a watchdog abort
//   count_o             words still to copy
//   wb_cyc_o..wb_dat_o  bus master outputs (cyc, stb, we, sel, adr, write data)
//   wb_ack_i, wb_stall_i, wb_dat_i  bus slave responses
module wb_copy_dma #(
    parameter int LWIDTH  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       src_i,
    input  logic [31:0]       dst_i,
    input  logic [LWIDTH-1:0] len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [LWIDTH-1:0] count_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_ack_i,
    input  logic              wb_stall_i,
    input  logic [31:0]       wb_dat_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t            r_state;
    logic [31:0]       r_src;
    logic [31:0]       r_dst;
    logic [31:0]       r_data;
    logic [LWIDTH-1:0] r_count;
    logic [15:0]       r_wd;
    logic              r_cyc;
    logic              r_stb;
    logic              r_we;
    logic [3:0]        r_sel;
    logic [31:0]       r_adr;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_in_req;
    logic              w_in_wait;
    logic              w_accept;
    logic              w_beat_ack;
    logic              w_is_wr;
    logic              w_wd_expire;
    logic [LWIDTH-1:0] w_count_dec;
    logic [31:0]       w_src_next;
    logic [31:0]       w_dst_next;
    logic              w_unused;

    assign w_in_req    = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
    assign w_in_wait   = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
    assign w_accept    = w_in_req && !wb_stall_i;
    // An ack belongs to the current beat either in the wait state or in the
    // very cycle the request is accepted (zero-latency slave).
    assign w_beat_ack  = wb_ack_i && (w_accept || w_in_wait);
    assign w_is_wr     = (r_state == S_WR_REQ) || (r_state == S_WR_WAIT);
    assign w_wd_expire = (TIMEOUT != 0) && (r_wd == WD_LAST);
    assign w_count_dec = r_count - LWIDTH'(1);
    assign w_src_next  = r_src + 32'd4;
    assign w_dst_next  = r_dst + 32'd4;
    assign w_unused    = ^{src_i[1:0], dst_i[1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_wd    <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_adr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_busy  <= 1'b1;
                        r_count <= len_i;
                        r_wd    <= '0;
                        if (len_i != '0) begin
                            r_state <= S_RD_REQ;
                            r_src   <= {src_i[31:2], 2'b00};
                            r_dst   <= {dst_i[31:2], 2'b00};
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_we    <= 1'b0;
                            r_sel   <= 4'b1111;
                            r_adr   <= {src_i[31:2], 2'b00};
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    if (w_beat_ack && w_is_wr) begin
                        // Word finished: advance pointers, then next read or finish.
                        r_wd    <= '0;
                        r_src   <= w_src_next;
                        r_dst   <= w_dst_next;
                        r_count <= w_count_dec;
                        if (w_count_dec == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_we    <= 1'b0;
                            r_sel   <= '0;
                        end else begin
                            r_state <= S_RD_REQ;
                            r_stb   <= 1'b1;
                            r_we    <= 1'b0;
                            r_adr   <= w_src_next;
                        end
                    end else if (w_beat_ack) begin
                        r_wd    <= '0;
                        r_data  <= wb_dat_i;
                        r_state <= S_WR_REQ;
                        r_stb   <= 1'b1;
                        r_we    <= 1'b1;
                        r_adr   <= r_dst;
                    end else if (w_accept) begin
                        r_wd    <= '0;
                        r_stb   <= 1'b0;
                        r_state <= (r_state == S_RD_REQ) ? S_RD_WAIT : S_WR_WAIT;
                    end else if (w_wd_expire) begin
                        // Abort: the in-flight word is not counted as copied.
                        r_wd    <= '0;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_sel   <= '0;
                    end else if (TIMEOUT != 0) begin
                        r_wd <= r_wd + 16'd1;
                    end
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign err_o    = r_err;
    assign count_o  = r_count;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_stb;
    assign wb_we_o  = r_we;
    assign wb_sel_o = r_sel;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_data;

endmodule

// File: tb/tb_wb_copy_dma.sv
// tb/tb_wb_copy_dma.sv - self-checking bench for wb_copy_dma with a pipelined RAM slave model
module tb_wb_copy_dma;

    localparam int TMO = 8;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] src_i   = '0;
    logic [31:0] dst_i   = '0;
    logic [15:0] len_i   = '0;
    logic        busy_o, done_o, err_o;
    logic [15:0] count_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic        wb_ack_i   = 1'b0;
    logic        wb_stall_i = 1'b0;
    logic [31:0] wb_dat_i   = '0;

    wb_copy_dma #(.LWIDTH(16), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .src_i(src_i), .dst_i(dst_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .count_o(count_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem[256];
    logic [31:0] ref_mem[256];
    bit          exp_we_q[$];
    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];

    int exp_len, wr_done, beat_idx, exp_edges, never_beat;
    bit pend, pend_never, pend_we;
    int pend_dly;
    logic [31:0] pend_adr, pend_dat;
    bit fresh, sl_rand, chk_en;
    int stall_left, cur_stall, sl_rd_stall, sl_wr_stall, sl_lat;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_ack(input bit we, input logic [31:0] adr, input logic [31:0] dat);
        wb_ack_i = 1'b1;
        if (we) begin
            mem[adr[9:2]] = dat;
            wr_done++;
        end else begin
            wb_dat_i = mem[adr[9:2]];
        end
    endtask

    // RAM slave: one request outstanding, per-beat stall count and ack latency.
    task automatic slave_step();
        bit          e_we, nv;
        logic [31:0] e_adr, e_dat;
        int          lat;
        wb_ack_i   = 1'b0;
        wb_dat_i   = $urandom;
        wb_stall_i = 1'($urandom_range(0, 1));
        if (rst_i) begin
            pend = 0;
            return;
        end
        if (chk_en && busy_o)
            check_eq("count_o", count_o, 64'(exp_len - wr_done));
        if (pend) begin
            if (wb_stb_o) check_eq("stb_while_pending", wb_stb_o, 0);
            if (!pend_never) begin
                if (pend_dly == 0) begin
                    do_ack(pend_we, pend_adr, pend_dat);
                    pend = 0;
                end else begin
                    pend_dly--;
                end
            end
        end else if (wb_cyc_o && wb_stb_o) begin
            if (fresh) begin
                stall_left = sl_rand ? $urandom_range(0, 3) : (wb_we_o ? sl_wr_stall : sl_rd_stall);
                cur_stall  = stall_left;
                fresh      = 0;
            end
            if (stall_left > 0) begin
                wb_stall_i = 1'b1;
                stall_left--;
            end else begin
                wb_stall_i = 1'b0;
                fresh      = 1;
                if (exp_we_q.size() == 0) begin
                    check_eq("extra_request", 1, 0);
                end else begin
                    e_we  = exp_we_q.pop_front();
                    e_adr = exp_adr_q.pop_front();
                    e_dat = exp_dat_q.pop_front();
                    check_eq("req_we", wb_we_o, e_we);
                    check_eq("req_adr", wb_adr_o, e_adr);
                    if (e_we) check_eq("req_dat", wb_dat_o, e_dat);
                    check_eq("req_sel", wb_sel_o, 4'hF);
                end
                lat = sl_rand ? $urandom_range(0, 3) : sl_lat;
                nv  = (beat_idx == never_beat);
                exp_edges += cur_stall + 1 + (nv ? TMO : lat);
                beat_idx++;
                if (!nv && lat == 0) begin
                    do_ack(wb_we_o, wb_adr_o, wb_dat_o);
                end else begin
                    pend       = 1;
                    pend_never = nv;
                    pend_dly   = lat - 1;
                    pend_we    = wb_we_o;
                    pend_adr   = wb_adr_o;
                    pend_dat   = wb_dat_o;
                end
            end
        end else if (!wb_cyc_o) begin
            wb_ack_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        slave_step();
    endtask

    // Reference: sequential word copy, expected bus request list, completed-word cutoff.
    task automatic prep(input logic [31:0] src, input logic [31:0] dst, input int len, input int nb,
                        input bit rnd, input int rs, input int ws, input int lat);
        logic [31:0] s, d, a_s, a_d, v;
        sl_rand = rnd; sl_rd_stall = rs; sl_wr_stall = ws; sl_lat = lat;
        never_beat = nb;
        exp_we_q.delete(); exp_adr_q.delete(); exp_dat_q.delete();
        exp_len = len; wr_done = 0; beat_idx = 0; exp_edges = 0;
        pend = 0; fresh = 1; stall_left = 0; cur_stall = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        s = src & ~32'd3;
        d = dst & ~32'd3;
        for (int i = 0; i < len; i++) begin
            a_s = s + 32'(4 * i);
            a_d = d + 32'(4 * i);
            v   = ref_mem[a_s[9:2]];
            exp_we_q.push_back(1'b0); exp_adr_q.push_back(a_s); exp_dat_q.push_back('0);
            exp_we_q.push_back(1'b1); exp_adr_q.push_back(a_d); exp_dat_q.push_back(v);
            if (nb < 0 || 2 * i + 1 < nb) ref_mem[a_d[9:2]] = v;
        end
    endtask

    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len, input int nb,
                            input bit inject, input bit rnd, input int rs, input int ws, input int lat);
        int edges;
        bit cyc_seen, exp_err;
        prep(src, dst, len, nb, rnd, rs, ws, lat);
        src_i = src; dst_i = dst; len_i = 16'(len); start_i = 1'b1; chk_en = 1;
        tick();
        start_i = 1'b0;
        check_eq("busy_start", busy_o, 1);
        cyc_seen = wb_cyc_o;
        edges = 0;
        while (!done_o && edges < 1000) begin
            start_i = inject && (edges == 1);
            if (start_i) begin
                src_i = $urandom; dst_i = $urandom; len_i = 16'($urandom_range(1, 9));
            end
            tick();
            edges++;
            cyc_seen |= wb_cyc_o;
        end
        start_i = 1'b0;
        exp_err = (nb >= 0) && (nb < 2 * len);
        check_eq("done_seen", done_o, 1);
        check_eq("done_edge", edges, exp_edges);
        check_eq("err_o", err_o, exp_err);
        check_eq("cyc_at_done", wb_cyc_o, 0);
        check_eq("stb_at_done", wb_stb_o, 0);
        check_eq("count_at_done", count_o, exp_err ? 64'(len - nb / 2) : 64'd0);
        if (len == 0) check_eq("cyc_len0", cyc_seen, 0);
        tick();
        check_eq("done_pulse", done_o, 0);
        check_eq("err_pulse", err_o, 0);
        check_eq("busy_after", busy_o, 0);
        chk_en = 0;
        for (int i = 0; i < 256; i++) check_eq($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
        check_eq("req_left", exp_we_q.size(), exp_err ? 64'(2 * len - (nb + 1)) : 64'd0);
        pend = 0;
    endtask

    initial begin
        bit found;
        int len, nb;
        chk_en = 0;
        never_beat = -1;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[32'h100 >> 2] = 32'hdeadbeef;

        tick();
        tick();
        check_eq("rst_cyc", wb_cyc_o, 0);
        check_eq("rst_stb", wb_stb_o, 0);
        check_eq("rst_we", wb_we_o, 0);
        check_eq("rst_sel", wb_sel_o, 0);
        check_eq("rst_adr", wb_adr_o, 0);
        check_eq("rst_dat", wb_dat_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_err", err_o, 0);
        check_eq("rst_count", count_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        tick();

        run_copy(32'h100, 32'h200, 1, -1, 0, 0, 0, 0, 1);
        check_eq("t1_word", mem[32'h200 >> 2], 32'hdeadbeef);
        run_copy(32'h0, 32'h40, 4, -1, 1, 0, 0, 0, 1);
        run_copy(32'h10, 32'h20, 0, -1, 0, 0, 0, 0, 1);
        run_copy(32'h300, 32'h380, 1, -1, 0, 0, 3, 0, 1);
        run_copy(32'h20, 32'h60, 5, 0, 0, 0, 0, 0, 1);
        run_copy(32'h80, 32'hC0, 4, 3, 0, 0, 0, 0, 1);
        run_copy(32'hFFFF_FFFB, 32'h2F3, 3, -1, 1, 0, 0, 0, 0);

        // Reset pulsed while the second word's write request is on the bus.
        prep(32'h0, 32'h3C0, 3, -1, 0, 0, 0, 1);
        src_i = 32'h0; dst_i = 32'h3C0; len_i = 16'd3; start_i = 1'b1; chk_en = 1;
        tick();
        start_i = 1'b0;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (wb_stb_o && wb_we_o && wr_done == 1) found = 1;
            else tick();
        end
        check_eq("t6_found", found, 1);
        #2 rst_i = 1'b1;
        chk_en = 0;
        #1;
        check_eq("t6_cyc", wb_cyc_o, 0);
        check_eq("t6_stb", wb_stb_o, 0);
        check_eq("t6_busy", busy_o, 0);
        check_eq("t6_count", count_o, 0);
        check_eq("t6_adr", wb_adr_o, 0);
        tick();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        tick();

        for (int r = 0; r < 14; r++) begin
            len = $urandom_range(0, 12);
            nb  = ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(0, 2 * len - 1) : -1;
            run_copy($urandom, $urandom, len, nb, 1'($urandom_range(0, 1)), 1, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
